// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  localparam int        BCD_W      = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_VAL    = 4'd3;

  // 10^n as a constant function, used for the digit-capacity check.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD nibble's add-3 correction applied before each shift.
import bcd_pkg::*;

module bcd_digit_adj (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  // 4-bit add; a nibble >= 5 never exceeds 9 here, so no carry is lost.
  assign o_nib = (i_nib >= ADJ_THRESH) ? (i_nib + ADJ_VAL) : i_nib;

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative double-dabble converter: one input bit per clock, registered
// result that only changes on completion or reset.
import bcd_pkg::*;

module bcd_seq_converter #(
  parameter int WIDTH_IN = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [WIDTH_IN-1:0]   i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int BCD_BITS = BCD_W * DIGITS;
  localparam int SR_W     = BCD_BITS + WIDTH_IN;
  localparam int CNT_W    = ($clog2(WIDTH_IN) > 0) ? $clog2(WIDTH_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_IN - 1);

  generate
    if (pow10(DIGITS) < (64'd1 << WIDTH_IN)) begin : g_bad_digits
      $error("bcd_seq_converter: DIGITS too small for WIDTH_IN");
    end
  endgenerate

  state_t               r_state, w_next_state;
  logic [SR_W-1:0]      r_sr;
  logic [CNT_W-1:0]     r_cnt;
  logic [BCD_BITS-1:0]  r_bcd;
  logic                 r_done;
  logic [SR_W-1:0]      w_adj, w_shift;
  logic                 w_load, w_step, w_last;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_nib (r_sr[WIDTH_IN + g*BCD_W +: BCD_W]),
        .o_nib (w_adj[WIDTH_IN + g*BCD_W +: BCD_W])
      );
    end
  endgenerate

  assign w_adj[WIDTH_IN-1:0] = r_sr[WIDTH_IN-1:0];
  assign w_shift             = {w_adj[SR_W-2:0], 1'b0};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = ST_CONV;
          w_load       = 1'b1;
        end
      end
      ST_CONV: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_next_state = ST_IDLE;
          w_last       = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_sr  <= {{BCD_BITS{1'b0}}, i_bin};
        r_cnt <= '0;
      end else if (w_step) begin
        r_sr  <= w_shift;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      // Publish only the finished field so the display never sees partial sums.
      if (w_last) r_bcd <= w_shift[SR_W-1 -: BCD_BITS];
    end
  end

  assign o_busy = (r_state == ST_CONV);
  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed and sweep bench for bcd_seq_converter (WIDTH_IN=8, DIGITS=3).
module tb_bcd_seq_converter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_bin = '0;
  logic        o_busy, o_done;
  logic [11:0] o_bcd;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_seq_converter #(.WIDTH_IN(8), .DIGITS(3)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_bin   (i_bin),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_bcd   (o_bcd)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Starts a conversion and waits (bounded) for o_done; no checking here.
  task automatic do_conv(input logic [7:0] v, input logic [11:0] prev,
                         output int lat, output int busy_n,
                         output logic [11:0] res, output logic stable);
    i_bin = v;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    busy_n = o_busy ? 1 : 0;
    stable = (o_bcd === prev);
    lat = 0;
    while (!o_done && lat < 20) begin
      tick();
      lat++;
      if (o_busy) busy_n++;
      if (!o_done && o_bcd !== prev) stable = 1'b0;
    end
    res = o_bcd;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_bcd !== 12'h000) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b bcd=%h, want 0 0 000", o_busy, o_done, o_bcd);
    end
  endtask

  task automatic test_zero();
    int lat, bn; logic [11:0] res; logic st;
    do_conv(8'd0, 12'h000, lat, bn, res, st);
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL zero_latency: got %0d want 8", lat); end
    n_checks++;
    if (bn !== 8) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 8", bn); end
    n_checks++;
    if (res !== 12'h000 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_result: bcd=%h busy=%b want 000 0", res, o_busy);
    end
    tick();
    n_checks++;
    if (o_done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: done=%b want 0", o_done); end
  endtask

  task automatic test_values();
    logic [7:0]  vin [3] = '{8'd255, 8'd128, 8'd99};
    logic [11:0] vexp[3] = '{12'h255, 12'h128, 12'h099};
    logic [11:0] prev;
    int lat, bn; logic [11:0] res; logic st;
    prev = 12'h000;
    for (int k = 0; k < 3; k++) begin
      do_conv(vin[k], prev, lat, bn, res, st);
      tick();
      n_checks++;
      if (res !== vexp[k] || lat !== 8) begin
        n_fail++;
        $display("FAIL value_%0d: bcd=%h lat=%0d want %h lat 8", vin[k], res, lat, vexp[k]);
      end
      n_checks++;
      if (!st) begin n_fail++; $display("FAIL hold_%0d: o_bcd changed before done, want %h held", vin[k], prev); end
      prev = vexp[k];
    end
  endtask

  task automatic test_busy_ignore();
    int pulses = 0;
    i_bin = 8'd200;
    i_start = 1'b1;
    tick();                 // E0
    i_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) i_bin = 8'd17;
      i_start = (c == 4);
      tick();
      if (o_done) begin
        pulses++;
        n_checks++;
        if (o_bcd !== 12'h200) begin n_fail++; $display("FAIL busy_ignore_result: bcd=%h want 200", o_bcd); end
      end
    end
    i_start = 1'b0;
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL busy_ignore_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    int lat, bn, n; logic [11:0] res; logic st;
    do_conv(8'd63, 12'h200, lat, bn, res, st);
    n_checks++;
    if (res !== 12'h063 || o_done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: bcd=%h done=%b want 063 1", res, o_done);
    end
    i_bin = 8'd64;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 1;
    while (!o_done && n < 20) begin tick(); n++; end
    n_checks++;
    if (n !== 9 || o_bcd !== 12'h064) begin
      n_fail++; $display("FAIL b2b_second: cycles=%0d bcd=%h want 9 064", n, o_bcd);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, bn, pulses; logic [11:0] res; logic st;
    do_conv(8'd150, 12'h064, lat, bn, res, st);
    tick();
    n_checks++;
    if (res !== 12'h150) begin n_fail++; $display("FAIL rst_pre: bcd=%h want 150", res); end
    i_bin = 8'd7;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick(); tick(); tick();
    pulses = o_done ? 1 : 0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    n_checks++;
    if (o_bcd !== 12'h000 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: bcd=%h busy=%b done=%b want 000 0 0", o_bcd, o_busy, o_done);
    end
    for (int c = 0; c < 12; c++) begin tick(); if (o_done) pulses++; end
    n_checks++;
    if (pulses !== 0 || o_bcd !== 12'h000) begin
      n_fail++; $display("FAIL rst_discard: pulses=%0d bcd=%h want 0 000", pulses, o_bcd);
    end
  endtask

  task automatic test_sweep();
    int lat, bn, dones = 0, bad = 0; logic [11:0] res, exp_v, prev; logic st;
    prev = 12'h000;
    for (int v = 0; v < 256; v++) begin
      exp_v = 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
      do_conv(8'(v), prev, lat, bn, res, st);
      if (o_done) dones++;
      n_checks++;
      if (res !== exp_v || lat !== 8 || !st) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL sweep_%0d: bcd=%h lat=%0d stable=%b want %h 8 1", v, res, lat, st, exp_v);
      end
      prev = exp_v;
    end
    n_checks++;
    if (dones !== 256) begin n_fail++; $display("FAIL sweep_done_count: got %0d want 256", dones); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_zero();
    test_values();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
